capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 112, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 112, rows per frame.
REQ-003 SHALL have parameter ADC_RES, default 8, sample width in bits.
REQ-004 SHALL have parameter SETTLE_TICKS, default 4, analog settle cycles before each conversion; legal range 1..255.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 64, maximum cycles per handshake phase; legal range 1..255.
REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port frameStart, input, 1, active-low frame request.
REQ-009 SHALL have port abort, input, 1, active-low frame abort.
REQ-010 SHALL have port adcStart, output, 1, active-low conversion request to the ADC driver.
REQ-011 SHALL have port adcDone, input, 1, active-low conversion-complete from the ADC driver.
REQ-012 SHALL have port adcData, input, ADC_RES, ADC sample.
REQ-013 SHALL have ports ptrReset, pixAdvance and rowAdvance, each an output of width 1: one-cycle active-high sensor pointer controls.
REQ-014 SHALL have port pixWe, output, 1, one-cycle active-high write strobe to the frame buffer.
REQ-015 SHALL have port pixAddr, output, clog2(IMG_W*IMG_H), row-major address (row*IMG_W+col).
REQ-016 SHALL have port pixData, output, ADC_RES, the registered sample.
REQ-017 SHALL have ports busy, frameDone and timeoutErr, each an output of width 1: busy level, one-cycle frameDone pulse, sticky timeoutErr.

Function
REQ-018 SHALL implement states IDLE, START, SETTLE, REQ, CONV, STORE, ADVANCE, DONE.
REQ-019 IDLE: on frameStart==0, SHALL go to START next cycle, clear row/col to 0, set busy=1 and clear timeoutErr.
REQ-020 START: SHALL pulse ptrReset for exactly one cycle, then go to SETTLE.
REQ-021 SETTLE: SHALL stay exactly SETTLE_TICKS cycles, then go to REQ.
REQ-022 REQ: SHALL hold adcStart=0 until adcDone==1 (request accepted, previous result cleared), then go to CONV with adcStart=1.
REQ-023 CONV: SHALL wait for adcDone==0, then capture adcData into pixData in that same cycle and go to STORE.
REQ-024 STORE: SHALL assert pixWe for one cycle, with pixAddr and pixData stable during that cycle.
REQ-025 ADVANCE, col<IMG_W-1: SHALL pulse pixAdvance, increment col, and go to SETTLE.
REQ-026 ADVANCE, col==IMG_W-1 and row<IMG_H-1: SHALL pulse rowAdvance, set col=0, increment row, and go to SETTLE.
REQ-027 ADVANCE, last pixel: SHALL issue no advance pulse and go to DONE.
REQ-028 DONE: SHALL pulse frameDone for one cycle, deassert busy, and return to IDLE.
REQ-029 Over a full frame, SHALL issue exactly IMG_W*IMG_H pixWe pulses, (IMG_W-1)*IMG_H pixAdvance pulses and IMG_H-1 rowAdvance pulses.
REQ-030 frameStart while busy SHALL be ignored, not queued.
REQ-031 A frameStart held low through DONE SHALL start a new frame only after one full cycle in IDLE.
REQ-032 abort==0 in any non-IDLE state SHALL force IDLE next cycle with adcStart=1, busy=0 and no frameDone pulse.
REQ-033 After abort, a conversion already in flight SHALL be allowed to finish, and its result SHALL be discarded.
REQ-034 abort SHALL take priority over every other transition, including a simultaneous STORE or DONE.
REQ-035 The timeout counter SHALL reload on entry to REQ and on entry to CONV.
REQ-036 If REQ or CONV lasts TIMEOUT_TICKS cycles, SHALL set timeoutErr, release adcStart, and go to IDLE without frameDone.
REQ-037 timeoutErr SHALL stay set until reset or the next accepted frameStart.
REQ-038 row and col SHALL never exceed IMG_H-1 and IMG_W-1; pixAddr SHALL not wrap within a frame.

Reset
REQ-039 reset==0 SHALL asynchronously force IDLE and set adcStart=1, busy=0, timeoutErr=0.
REQ-040 reset==0 SHALL asynchronously clear ptrReset, pixAdvance, rowAdvance, pixWe and frameDone to 0, and clear pixAddr, pixData, row, col and all counters to 0.
REQ-041 Reset mid-frame SHALL behave as abort, except that it also clears timeoutErr.

Structure
REQ-042 A shared package SHALL hold the state encoding, the active-low level constants and the default IMG_W, IMG_H and ADC_RES values shared with the ADC driver and frame buffer.
REQ-043 The block SHALL have no sub-module; the settle counter and the timeout counter SHALL share one 8-bit down-counter.

Verification (IMG_W=3, IMG_H=2, SETTLE_TICKS=2, TIMEOUT_TICKS=16, behavioral ADC model returning 0x10+index)
REQ-044 Bench SHALL check: one frameStart pulse -> 6 pixWe writing addresses 0..5 with data 0x10..0x15, 4 pixAdvance, 1 rowAdvance, 1 ptrReset, one frameDone, and busy low afterwards.
REQ-045 Bench SHALL check: second frameStart during pixel 2 -> ignored, exactly 6 writes, one frameDone.
REQ-046 Bench SHALL check: ADC model never deasserts adcDone in REQ -> timeoutErr=1 after 16 cycles, adcStart=1, busy=0, no frameDone.
REQ-047 Bench SHALL check: abort asserted in CONV of pixel 3 -> no further pixWe, busy=0 next cycle, no frameDone; next frame restarts at address 0.
REQ-048 Bench SHALL check: reset asserted mid-SETTLE -> outputs take reset values immediately with no clock edge; next frame completes all 6 writes.
REQ-049 Bench SHALL check: frameStart held low continuously -> back-to-back frames with at least one IDLE cycle between frameDone and the next ptrReset.

Source files
------------

// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the image capture path: sequencer state encoding,
// active-low level constants and the default geometry/sample width that the
// ADC driver and frame buffer are built against.
package capture_sequencer_pkg;

    localparam int unsigned DEF_IMG_W   = 112;
    localparam int unsigned DEF_IMG_H   = 112;
    localparam int unsigned DEF_ADC_RES = 8;

    // Levels for the active-low control lines (frameStart, abort, adcStart, adcDone).
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        REQ,
        CONV,
        STORE,
        ADVANCE,
        DONE
    } seqState_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned widthOf(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// ADC handshake and frame-buffer write port of the capture sequencer.
// master = sequencer side, slave = ADC driver / frame buffer side.
interface capture_sequencer_if
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned ADC_RES = DEF_ADC_RES,
    parameter int unsigned ADDR_W  = widthOf(DEF_IMG_W * DEF_IMG_H)
) ();

    logic               adcStart;
    logic               adcDone;
    logic [ADC_RES-1:0] adcData;
    logic               pixWe;
    logic [ADDR_W-1:0]  pixAddr;
    logic [ADC_RES-1:0] pixData;

    modport master (
        output adcStart,
        input  adcDone,
        input  adcData,
        output pixWe,
        output pixAddr,
        output pixData
    );

    modport slave (
        input  adcStart,
        output adcDone,
        output adcData,
        input  pixWe,
        input  pixAddr,
        input  pixData
    );

endinterface

// File: rtl/capture_sequencer.sv
// Frame capture sequencer: walks the sensor pointer row-major across the
// image, runs one settle + ADC handshake per pixel and writes each sample to
// the frame buffer. A single 8-bit down-counter times both the settle window
// and the per-phase handshake timeout.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned IMG_W         = DEF_IMG_W,
    parameter int unsigned IMG_H         = DEF_IMG_H,
    parameter int unsigned ADC_RES       = DEF_ADC_RES,
    parameter int unsigned SETTLE_TICKS  = 4,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frameStart,
    input  logic                abort,
    capture_sequencer_if.master bus,
    output logic                ptrReset,
    output logic                pixAdvance,
    output logic                rowAdvance,
    output logic                busy,
    output logic                frameDone,
    output logic                timeoutErr
);

    localparam int unsigned COL_W  = widthOf(IMG_W);
    localparam int unsigned ROW_W  = widthOf(IMG_H);
    localparam int unsigned ADDR_W = widthOf(IMG_W * IMG_H);

    localparam logic [COL_W-1:0] LAST_COL     = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(IMG_H - 1);
    localparam logic [7:0]       SETTLE_LOAD  = 8'(SETTLE_TICKS - 1);
    localparam logic [7:0]       TIMEOUT_LOAD = 8'(TIMEOUT_TICKS - 1);

    seqState_e          state;
    seqState_e          nextState;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr;
    logic [ADC_RES-1:0] sample;
    logic [7:0]         tick;

    logic startReq;
    logic abortReq;
    logic lastCol;
    logic lastRow;
    logic tickZero;
    logic timedOut;

    assign startReq = (frameStart == ASSERT_L);
    assign abortReq = (abort == ASSERT_L);
    assign lastCol  = (col == LAST_COL);
    assign lastRow  = (row == LAST_ROW);
    assign tickZero = (tick == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        nextState = state;
        timedOut  = 1'b0;
        if (state != IDLE && abortReq) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (startReq) nextState = START;
                START:   nextState = SETTLE;
                SETTLE:  if (tickZero) nextState = REQ;
                REQ: begin
                    // A handshake completing in the final allowed cycle still wins.
                    if (bus.adcDone == DEASSERT_L) begin
                        nextState = CONV;
                    end else if (tickZero) begin
                        nextState = IDLE;
                        timedOut  = 1'b1;
                    end
                end
                CONV: begin
                    if (bus.adcDone == ASSERT_L) begin
                        nextState = STORE;
                    end else if (tickZero) begin
                        nextState = IDLE;
                        timedOut  = 1'b1;
                    end
                end
                STORE:   nextState = ADVANCE;
                ADVANCE: nextState = (lastCol && lastRow) ? DONE : SETTLE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; pulses are suppressed in a cycle that aborts
    always_comb begin
        bus.adcStart = (state == REQ) ? ASSERT_L : DEASSERT_L;
        bus.pixWe    = (state == STORE) && !abortReq;
        bus.pixAddr  = addr;
        bus.pixData  = sample;
        ptrReset     = (state == START) && !abortReq;
        pixAdvance   = (state == ADVANCE) && !abortReq && !lastCol;
        rowAdvance   = (state == ADVANCE) && !abortReq && lastCol && !lastRow;
        frameDone    = (state == DONE) && !abortReq;
        busy         = (state != IDLE);
    end

    // Pixel position, captured sample and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            sample     <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == IDLE && nextState == START) begin
                col        <= '0;
                row        <= '0;
                addr       <= '0;
                timeoutErr <= 1'b0;
            end
            if (timedOut) begin
                timeoutErr <= 1'b1;
            end
            if (state == CONV && nextState == STORE) begin
                sample <= bus.adcData;
            end
            // Row-major order means the address steps by one on either advance.
            if (state == ADVANCE && nextState == SETTLE) begin
                addr <= addr + ADDR_W'(1);
                if (lastCol) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Shared settle/timeout down-counter, reloaded on every state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= '0;
        end else if (nextState != state) begin
            case (nextState)
                SETTLE:    tick <= SETTLE_LOAD;
                REQ, CONV: tick <= TIMEOUT_LOAD;
                default:   tick <= '0;
            endcase
        end else if (!tickZero) begin
            tick <= tick - 8'd1;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer on a 3x2 image with a behavioural ADC
// that returns 0x10 + conversion index since the last pointer reset.
module tb_capture_sequencer;

    localparam int unsigned W = 3;
    localparam int unsigned H = 2;
    localparam int unsigned NPIX = W * H;

    logic clk;
    logic reset;
    logic frameStart;
    logic abort;
    logic ptrReset;
    logic pixAdvance;
    logic rowAdvance;
    logic busy;
    logic frameDone;
    logic timeoutErr;

    capture_sequencer_if #(.ADC_RES(8), .ADDR_W(3)) bus ();

    capture_sequencer #(
        .IMG_W(W),
        .IMG_H(H),
        .ADC_RES(8),
        .SETTLE_TICKS(2),
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frameStart(frameStart),
        .abort(abort),
        .bus(bus),
        .ptrReset(ptrReset),
        .pixAdvance(pixAdvance),
        .rowAdvance(rowAdvance),
        .busy(busy),
        .frameDone(frameDone),
        .timeoutErr(timeoutErr)
    );

    int compared = 0;
    int mismatched = 0;

    // Observed event totals and write log
    int totWrites = 0, totDone = 0, totPtr = 0, totPixAdv = 0, totRowAdv = 0;
    int logAddr [0:255];
    int logData [0:255];
    int lastReqLen = 0;

    // ADC model state
    logic adcStall = 1'b0;
    int adcPhase = 0, adcWait = 0, adcIdx = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural ADC: accept request (adcDone high), convert for three cycles, present result (adcDone low)
    initial begin : adcModel
        bus.adcDone = 1'b0;
        bus.adcData = '0;
        forever begin
            @(negedge clk);
            if (ptrReset) adcIdx = 0;
            if (adcPhase == 0) begin
                if (bus.adcStart == 1'b0 && !adcStall) begin
                    bus.adcDone = 1'b1;
                    adcWait = 2;
                    adcPhase = 1;
                end
            end else if (adcWait != 0) begin
                adcWait--;
            end else begin
                bus.adcDone = 1'b0;
                bus.adcData = 8'(8'h10 + adcIdx);
                adcIdx++;
                adcPhase = 0;
            end
        end
    end

    // Reference model: tracks frame position from the advance pulses and checks every cycle
    initial begin : compareProc
        int cyc = 0, fWrites = 0, fPixAdv = 0, fRowAdv = 0, mRow = 0, mCol = 0;
        int lastDoneCyc = 0, anchorCyc = 0, anchorGap = 0, reqRun = 0;
        bit doneSeen = 0, prevDone = 0, anchorValid = 0;
        logic prevAdcStart = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("pulseOnehot", int'($countones({ptrReset, bus.pixWe, pixAdvance, rowAdvance, frameDone}) <= 1), 1);
                check("reqImpliesBusy", int'(bus.adcStart | busy), 1);
                if (prevDone) check("busyAfterDone", busy, 0);
                if (bus.adcStart == 1'b0 && prevAdcStart == 1'b1 && anchorValid) begin
                    check("settleSpacing", cyc - anchorCyc, anchorGap);
                    anchorValid = 0;
                end
                if (bus.adcStart == 1'b0) begin
                    reqRun++;
                end else if (reqRun != 0) begin
                    lastReqLen = reqRun;
                    reqRun = 0;
                end
                if (ptrReset) begin
                    totPtr++;
                    if (doneSeen) check("idleGap", int'((cyc - lastDoneCyc) >= 2), 1);
                    fWrites = 0; fPixAdv = 0; fRowAdv = 0; mRow = 0; mCol = 0;
                    anchorValid = 1; anchorCyc = cyc; anchorGap = 3;
                end
                if (bus.pixWe) begin
                    check("pixAddrOrder", bus.pixAddr, fWrites);
                    check("pixAddrPos", bus.pixAddr, mRow * W + mCol);
                    check("pixData", bus.pixData, 16 + fWrites);
                    logAddr[totWrites[7:0]] = bus.pixAddr;
                    logData[totWrites[7:0]] = bus.pixData;
                    fWrites++;
                    totWrites++;
                    if (fWrites < NPIX) begin
                        anchorValid = 1; anchorCyc = cyc; anchorGap = 4;
                    end
                end
                if (pixAdvance) begin
                    check("pixAdvInRow", int'(mCol < W - 1), 1);
                    mCol++; fPixAdv++; totPixAdv++;
                end
                if (rowAdvance) begin
                    check("rowAdvAtEnd", int'(mCol == W - 1 && mRow < H - 1), 1);
                    mCol = 0; mRow++; fRowAdv++; totRowAdv++;
                end
                if (frameDone) begin
                    check("frameWrites", fWrites, NPIX);
                    check("framePixAdv", fPixAdv, (W - 1) * H);
                    check("frameRowAdv", fRowAdv, H - 1);
                    totDone++;
                    doneSeen = 1;
                    lastDoneCyc = cyc;
                end
                prevDone = frameDone;
                prevAdcStart = bus.adcStart;
            end else begin
                prevDone = 0;
                prevAdcStart = 1'b1;
                reqRun = 0;
                anchorValid = 0;
            end
        end
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 frameStart = 1'b0;
        @(posedge clk);
        #1 frameStart = 1'b1;
    endtask

    task automatic waitDoneCount(input int target, input string name);
        for (int k = 0; k < 400 && totDone < target; k++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_reached"}, int'(totDone >= target), 1);
    endtask

    task automatic waitWrites(input int target, input string name);
        for (int k = 0; k < 400 && totWrites < target; k++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_reached"}, int'(totWrites >= target), 1);
    endtask

    task automatic waitAdcStart(input logic level, input string name);
        for (int k = 0; k < 100 && bus.adcStart != level; k++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_reached"}, int'(bus.adcStart == level), 1);
    endtask

    initial begin : driver
        int bW, bD, bP, bPA, bRA;
        reset = 1'b0;
        frameStart = 1'b1;
        abort = 1'b1;

        #1;
        check("rst_adcStart", bus.adcStart, 1);
        check("rst_busy", busy, 0);
        check("rst_timeoutErr", timeoutErr, 0);
        check("rst_ptrReset", ptrReset, 0);
        check("rst_pixWe", bus.pixWe, 0);
        check("rst_pixAdvance", pixAdvance, 0);
        check("rst_rowAdvance", rowAdvance, 0);
        check("rst_frameDone", frameDone, 0);
        check("rst_pixAddr", bus.pixAddr, 0);
        check("rst_pixData", bus.pixData, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        waitCycles(2);

        // Single frame
        bW = totWrites; bD = totDone; bP = totPtr; bPA = totPixAdv; bRA = totRowAdv;
        pulseStart();
        check("s1_busyStart", busy, 1);
        waitDoneCount(bD + 1, "s1_done");
        waitCycles(3);
        check("s1_writes", totWrites - bW, 6);
        check("s1_pixAdv", totPixAdv - bPA, 4);
        check("s1_rowAdv", totRowAdv - bRA, 1);
        check("s1_ptrReset", totPtr - bP, 1);
        check("s1_frameDone", totDone - bD, 1);
        check("s1_busyAfter", busy, 0);
        check("s1_firstAddr", logAddr[bW], 0);
        check("s1_firstData", logData[bW], 'h10);
        check("s1_lastAddr", logAddr[bW + 5], 5);
        check("s1_lastData", logData[bW + 5], 'h15);

        // frameStart during a frame is ignored
        bW = totWrites; bD = totDone; bP = totPtr;
        pulseStart();
        waitWrites(bW + 2, "s2_pix2");
        pulseStart();
        waitDoneCount(bD + 1, "s2_done");
        waitCycles(60);
        check("s2_writes", totWrites - bW, 6);
        check("s2_frameDone", totDone - bD, 1);
        check("s2_ptrReset", totPtr - bP, 1);
        check("s2_busyAfter", busy, 0);

        // ADC never accepts: handshake timeout
        bW = totWrites; bD = totDone;
        adcStall = 1'b1;
        pulseStart();
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        waitCycles(2);
        check("s3_timeoutErr", timeoutErr, 1);
        check("s3_adcStart", bus.adcStart, 1);
        check("s3_busy", busy, 0);
        check("s3_reqLen", lastReqLen, 16);
        check("s3_noDone", totDone - bD, 0);
        check("s3_noWrites", totWrites - bW, 0);
        adcStall = 1'b0;
        waitCycles(5);
        check("s3_sticky", timeoutErr, 1);

        // Abort during the conversion of pixel 3
        bW = totWrites; bD = totDone;
        pulseStart();
        check("s4_errCleared", timeoutErr, 0);
        waitWrites(bW + 3, "s4_pix3");
        waitAdcStart(1'b0, "s4_req");
        waitAdcStart(1'b1, "s4_conv");
        check("s4_busyInConv", busy, 1);
        abort = 1'b0;
        @(posedge clk);
        #1;
        check("s4_busyAbort", busy, 0);
        check("s4_adcStartAbort", bus.adcStart, 1);
        abort = 1'b1;
        waitCycles(30);
        check("s4_writes", totWrites - bW, 3);
        check("s4_noDone", totDone - bD, 0);
        bW = totWrites; bD = totDone;
        pulseStart();
        waitDoneCount(bD + 1, "s4b_done");
        waitCycles(3);
        check("s4b_writes", totWrites - bW, 6);
        check("s4b_firstAddr", logAddr[bW], 0);
        check("s4b_firstData", logData[bW], 'h10);

        // Asynchronous reset in SETTLE
        bW = totWrites; bD = totDone;
        pulseStart();
        check("s5_ptrReset", ptrReset, 1);
        @(posedge clk);
        #1;
        check("s5_busyPre", busy, 1);
        check("s5_pixDataPre", bus.pixData, 'h15);
        #2 reset = 1'b0;
        #1;
        check("s5_busy", busy, 0);
        check("s5_adcStart", bus.adcStart, 1);
        check("s5_timeoutErr", timeoutErr, 0);
        check("s5_ptrResetLow", ptrReset, 0);
        check("s5_pixAdvance", pixAdvance, 0);
        check("s5_rowAdvance", rowAdvance, 0);
        check("s5_frameDone", frameDone, 0);
        check("s5_pixWe", bus.pixWe, 0);
        check("s5_pixAddr", bus.pixAddr, 0);
        check("s5_pixData", bus.pixData, 0);
        @(negedge clk);
        reset = 1'b1;
        waitCycles(3);
        check("s5_idle", busy, 0);
        pulseStart();
        waitDoneCount(bD + 1, "s5_done");
        waitCycles(3);
        check("s5_writes", totWrites - bW, 6);

        // frameStart held low: back-to-back frames
        bW = totWrites; bD = totDone; bP = totPtr;
        @(posedge clk);
        #1 frameStart = 1'b0;
        for (int k = 0; k < 800 && totDone < bD + 2; k++) begin
            @(posedge clk);
            #1;
        end
        frameStart = 1'b1;
        check("s6_reached", int'(totDone >= bD + 2), 1);
        waitCycles(5);
        check("s6_frames", totDone - bD, 2);
        check("s6_writes", totWrites - bW, 12);
        check("s6_ptrReset", totPtr - bP, 2);
        check("s6_busyAfter", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
